// File: rtl/core_arb_pkg.sv
// core_arb_pkg: shared sizes, FSM states and one-hot helper for the memory arbiter
package core_arb_pkg;
  localparam int N_CORES = 16;
  localparam int IDX_W = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  function automatic logic [N_CORES-1:0] onehot(input logic [IDX_W-1:0] i);
    return N_CORES'(1) << i;
  endfunction
endpackage

// File: rtl/core_mem_arbiter_rr_pick.sv
// rr_pick: first eligible index scanning from ptr upward with wrap-around
module rr_pick
  import core_arb_pkg::*;
(
  input  logic [N_CORES-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   pick
);
  always_comb begin
    valid = 1'b0;
    pick = '0;
    for (int k = N_CORES - 1; k >= 0; k--)
      if (eligible[(int'(ptr) + k) % N_CORES]) begin
        valid = 1'b1;
        pick = IDX_W'((int'(ptr) + k) % N_CORES);
      end
  end
endmodule

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: round-robin sharing of one data-memory port among enabled cores
module core_mem_arbiter
  import core_arb_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CORES-1:0]        core_en,
  input  logic [N_CORES-1:0]        req,
  input  logic [N_CORES-1:0]        we,
  input  logic [N_CORES*ADDR_W-1:0] addr,
  input  logic [N_CORES*DATA_W-1:0] wdata,
  output logic [N_CORES-1:0]        grant,
  output logic [N_CORES-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic [IDX_W-1:0]          owner
);
  state_t state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick;
  logic valid;
  rr_pick u_pick (.eligible(req & core_en), .ptr(ptr), .valid(valid), .pick(pick));
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      grant <= '0;
      ack <= '0;
      rdata <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (valid) begin
            owner <= pick;
            grant <= onehot(pick);
            mem_we <= we[pick];
            mem_addr <= addr[pick*ADDR_W +: ADDR_W];
            mem_wdata <= wdata[pick*DATA_W +: DATA_W];
            mem_req <= 1'b1;
            ptr <= IDX_W'((int'(pick) + 1) % N_CORES);
            state <= BUSY;
          end
        end
        BUSY:
          if (mem_ready) begin
            rdata <= mem_rdata;
            ack <= onehot(owner);
            mem_req <= 1'b0;
            state <= ACK;
          end
        ACK: begin
          grant <= '0;
          ack <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed self-checking bench for the core memory arbiter
module tb_core_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] core_en, req, we, grant, ack, rdata, mem_wdata, mem_rdata;
  logic [127:0] addr;
  logic [255:0] wdata;
  logic mem_req, mem_we, mem_ready, busy;
  logic [7:0] mem_addr;
  logic [3:0] owner;
  int checks = 0;
  int failures = 0;

  core_mem_arbiter dut (
    .clk(clk), .reset(reset), .core_en(core_en), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .grant(grant), .ack(ack), .rdata(rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    core_en = 16'h0; req = 16'h0; we = 16'h0; addr = '0; wdata = '0;
    mem_rdata = 16'h0; mem_ready = 1'b0;
    step();
    step();
    checks++;
    if ({grant, ack, rdata} !== 48'h0) begin
      failures++;
      $display("FAIL reset_grant_ack_rdata: got %h expected 0", {grant, ack, rdata});
    end
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, busy, owner} !== 31'h0) begin
      failures++;
      $display("FAIL reset_mem_busy_owner: got %h expected 0", {mem_req, mem_we, mem_addr, mem_wdata, busy, owner});
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    core_en = 16'h0033; req = 16'h0001; we = 16'h0; addr[7:0] = 8'h12;
    step();
    checks++;
    if ({mem_req, mem_addr, mem_we, grant, busy, owner} !== {1'b1, 8'h12, 1'b0, 16'h0001, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL single_busy: got req=%b addr=%h we=%b grant=%h busy=%b owner=%0d expected 1 12 0 0001 1 0",
               mem_req, mem_addr, mem_we, grant, busy, owner);
    end
    checks++;
    if (ack !== 16'h0) begin
      failures++;
      $display("FAIL single_no_early_ack: got %h expected 0000", ack);
    end
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    step();
    checks++;
    if ({ack, rdata, grant, mem_req, busy} !== {16'h0001, 16'hBEEF, 16'h0001, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL single_ack: got ack=%h rdata=%h grant=%h mem_req=%b busy=%b expected 0001 beef 0001 0 1",
               ack, rdata, grant, mem_req, busy);
    end
    mem_ready = 1'b0; req = 16'h0;
    step();
    checks++;
    if ({ack, grant, busy} !== 33'h0) begin
      failures++;
      $display("FAIL single_idle: got ack=%h grant=%h busy=%b expected 0", ack, grant, busy);
    end
    step();
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL single_no_repeat: got mem_req=%b expected 0", mem_req);
    end
  endtask

  task automatic test_round_robin();
    int exp_owner[5] = '{0, 2, 7, 0, 2};
    bit ok;
    reset = 1'b1;
    step();
    reset = 1'b0; core_en = 16'h00FF; req = 16'h0085;
    for (int j = 0; j < 5; j++) begin
      wait_req(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rr_wait_%0d: got no mem_req expected mem_req within 10 cycles", j);
      end
      checks++;
      if ({owner, grant} !== {4'(exp_owner[j]), 16'(1 << exp_owner[j])}) begin
        failures++;
        $display("FAIL rr_owner_%0d: got owner=%0d grant=%h expected owner=%0d", j, owner, grant, exp_owner[j]);
      end
      mem_ready = 1'b1; mem_rdata = 16'(j);
      step();
      checks++;
      if (ack !== 16'(1 << exp_owner[j])) begin
        failures++;
        $display("FAIL rr_ack_%0d: got %h expected core %0d", j, ack, exp_owner[j]);
      end
      mem_ready = 1'b0;
      step();
    end
    req = 16'h0;
    step();
  endtask

  task automatic test_masking();
    core_en = 16'h0001; req = 16'h0006;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({mem_req, busy, grant} !== 18'h0) begin
        failures++;
        $display("FAIL mask_idle_%0d: got mem_req=%b busy=%b grant=%h expected 0", i, mem_req, busy, grant);
      end
    end
    core_en = 16'h0033;
    step();
    checks++;
    if ({grant, owner, mem_req} !== {16'h0002, 4'd1, 1'b1}) begin
      failures++;
      $display("FAIL mask_enable_grant: got grant=%h owner=%0d mem_req=%b expected 0002 1 1", grant, owner, mem_req);
    end
    mem_ready = 1'b1;
    step();
    checks++;
    if (ack !== 16'h0002) begin
      failures++;
      $display("FAIL mask_ack: got %h expected 0002", ack);
    end
    mem_ready = 1'b0; req = 16'h0;
    step();
  endtask

  task automatic test_stall();
    core_en = 16'h00FF; req = 16'h0008; we = 16'h0008;
    addr[3*8 +: 8] = 8'h34; wdata[3*16 +: 16] = 16'h5A5A;
    step();
    checks++;
    if ({grant, mem_req, mem_we, mem_addr, mem_wdata} !== {16'h0008, 1'b1, 1'b1, 8'h34, 16'h5A5A}) begin
      failures++;
      $display("FAIL stall_grant: got grant=%h req=%b we=%b addr=%h wdata=%h expected 0008 1 1 34 5a5a",
               grant, mem_req, mem_we, mem_addr, mem_wdata);
    end
    addr[3*8 +: 8] = 8'h99; wdata[3*16 +: 16] = 16'h1111; core_en = 16'h00F7; req = 16'h0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({mem_req, mem_addr, mem_wdata, ack} !== {1'b1, 8'h34, 16'h5A5A, 16'h0}) begin
        failures++;
        $display("FAIL stall_hold_%0d: got req=%b addr=%h wdata=%h ack=%h expected 1 34 5a5a 0000",
                 i, mem_req, mem_addr, mem_wdata, ack);
      end
    end
    mem_ready = 1'b1; mem_rdata = 16'h1234;
    step();
    checks++;
    if ({ack, rdata, mem_req} !== {16'h0008, 16'h1234, 1'b0}) begin
      failures++;
      $display("FAIL stall_ack: got ack=%h rdata=%h mem_req=%b expected 0008 1234 0", ack, rdata, mem_req);
    end
    we = 16'h0; mem_rdata = 16'hDEAD;
    step();
    step();
    checks++;
    if ({ack, rdata, mem_req, busy} !== {16'h0, 16'h1234, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL stray_ready: got ack=%h rdata=%h mem_req=%b busy=%b expected 0000 1234 0 0", ack, rdata, mem_req, busy);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    core_en = 16'hFFFF; req = 16'h0010;
    step();
    checks++;
    if ({owner, mem_req} !== {4'd4, 1'b1}) begin
      failures++;
      $display("FAIL rmid_grant: got owner=%0d mem_req=%b expected 4 1", owner, mem_req);
    end
    step();
    reset = 1'b1;
    step();
    checks++;
    if ({grant, ack, rdata, mem_req, mem_we, mem_addr, mem_wdata, busy, owner} !== 79'h0) begin
      failures++;
      $display("FAIL rmid_clear: got grant=%h ack=%h rdata=%h mem_req=%b addr=%h busy=%b owner=%0d expected 0",
               grant, ack, rdata, mem_req, mem_addr, busy, owner);
    end
    reset = 1'b0; mem_ready = 1'b1; req = 16'h0;
    step();
    checks++;
    if ({ack, busy} !== 17'h0) begin
      failures++;
      $display("FAIL rmid_no_ack: got ack=%h busy=%b expected 0", ack, busy);
    end
    mem_ready = 1'b0; req = 16'h0042;
    step();
    checks++;
    if ({grant, owner} !== {16'h0002, 4'd1}) begin
      failures++;
      $display("FAIL rmid_ptr_zero: got grant=%h owner=%0d expected 0002 1", grant, owner);
    end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0; req = 16'h0;
    step();
  endtask

  task automatic test_back_to_back();
    core_en = 16'hFFFF; req = 16'h0020; mem_ready = 1'b1; mem_rdata = 16'hCAFE;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if ({busy, ack} !== {i % 3 != 2, (i % 3 == 1) ? 16'h0020 : 16'h0}) begin
        failures++;
        $display("FAIL b2b_%0d: got busy=%b ack=%h expected busy=%b ack=%h",
                 i, busy, ack, i % 3 != 2, (i % 3 == 1) ? 16'h0020 : 16'h0);
      end
    end
    checks++;
    if ({owner, rdata} !== {4'd5, 16'hCAFE}) begin
      failures++;
      $display("FAIL b2b_owner_rdata: got owner=%0d rdata=%h expected 5 cafe", owner, rdata);
    end
    req = 16'h0; mem_ready = 1'b0;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_masking();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
